fb_write_scheduler: RTL

- Shares the single 1-bit framebuffer write port (640x480, 19-bit linear address) between two requesters and one built-in sequencer.
- Requesters: the mouse stroke writer (M) and the text/glyph writer (T).
- Built-in sequencer: a full-screen clear engine (C).
- Sits between the drawing sources and the framebuffer RAM write port, and issues at most one write per clock.

---
 rtl/fb_write_scheduler_if.sv | 30 +++
 rtl/fb_write_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fb_write_scheduler_if.sv
// Bundle of the clear-request, two requester ports and framebuffer write port
// shared by the write scheduler and the drawing side.
interface fb_write_scheduler_if #(
  parameter int ADDR_W = 19
) ();
  logic              clear_req;
  logic              clear_busy;
  logic              m_req;
  logic [ADDR_W-1:0] m_addr;
  logic              m_data;
  logic              m_ack;
  logic              t_req;
  logic [ADDR_W-1:0] t_addr;
  logic              t_data;
  logic              t_ack;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_data;
  logic [15:0]       drop_cnt;

  modport master (
    output clear_req, m_req, m_addr, m_data, t_req, t_addr, t_data,
    input  clear_busy, m_ack, t_ack, fb_we, fb_addr, fb_data, drop_cnt
  );

  modport slave (
    input  clear_req, m_req, m_addr, m_data, t_req, t_addr, t_data,
    output clear_busy, m_ack, t_ack, fb_we, fb_addr, fb_data, drop_cnt
  );
endinterface

// File: rtl/fb_write_scheduler.sv
// Single-port framebuffer write scheduler: round-robin between the mouse and
// text writers, with a built-in full-screen clear sequencer that takes priority.
module fb_write_scheduler #(
  parameter int FB_DEPTH = 307200,
  parameter int ADDR_W   = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  fb_write_scheduler_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic              SRC_M     = 1'b0;
  localparam logic              SRC_T     = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_L   = ADDR_W'(FB_DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last;
  logic              r_fb_we;
  logic [ADDR_W-1:0] r_fb_addr;
  logic              r_fb_data;
  logic              r_busy;
  logic [15:0]       r_drop_cnt;

  logic              w_final;
  logic              w_arb_en;
  logic              w_grant_m;
  logic              w_grant_t;
  logic              w_grant;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic              w_gnt_data;
  logic              w_in_range;
  logic              w_drop;
  logic              w_fb_we_nxt;
  logic [ADDR_W-1:0] w_fb_addr_nxt;
  logic              w_fb_data_nxt;
  logic              w_busy_nxt;

  // Arbitration window: idle ARB cycles without clear_req, plus the last clear cycle.
  always_comb begin
    w_final    = (r_state == ST_CLEAR) && (r_fb_addr == LAST_ADDR);
    w_arb_en   = ((r_state == ST_ARB) && !bus.clear_req) || w_final;
    w_grant_m  = 1'b0;
    w_grant_t  = 1'b0;
    if (w_arb_en) begin
      if (bus.m_req && bus.t_req) begin
        if (r_last == SRC_T) begin
          w_grant_m = 1'b1;
        end else begin
          w_grant_t = 1'b1;
        end
      end else begin
        w_grant_m = bus.m_req;
        w_grant_t = bus.t_req;
      end
    end else begin
      w_grant_m = 1'b0;
      w_grant_t = 1'b0;
    end
    w_grant = w_grant_m | w_grant_t;
    if (w_grant_t) begin
      w_gnt_addr = bus.t_addr;
      w_gnt_data = bus.t_data;
    end else begin
      w_gnt_addr = bus.m_addr;
      w_gnt_data = bus.m_data;
    end
    w_in_range = (w_gnt_addr < DEPTH_L);
    w_drop     = w_grant && !w_in_range;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARB: begin
        if (bus.clear_req) begin
          w_state_nxt = ST_CLEAR;
        end else begin
          w_state_nxt = ST_ARB;
        end
      end
      ST_CLEAR: begin
        if (w_final) begin
          w_state_nxt = ST_ARB;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  // Next values of the registered write port; a missing grant holds addr/data.
  always_comb begin
    w_fb_we_nxt   = 1'b0;
    w_fb_addr_nxt = r_fb_addr;
    w_fb_data_nxt = r_fb_data;
    w_busy_nxt    = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (bus.clear_req) begin
          w_fb_we_nxt   = 1'b1;
          w_fb_addr_nxt = '0;
          w_fb_data_nxt = 1'b0;
          w_busy_nxt    = 1'b1;
        end else if (w_grant && w_in_range) begin
          w_fb_we_nxt   = 1'b1;
          w_fb_addr_nxt = w_gnt_addr;
          w_fb_data_nxt = w_gnt_data;
        end else begin
          w_fb_we_nxt   = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (!w_final) begin
          w_fb_we_nxt   = 1'b1;
          w_fb_addr_nxt = r_fb_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          w_fb_data_nxt = 1'b0;
          w_busy_nxt    = 1'b1;
        end else if (w_grant && w_in_range) begin
          w_fb_we_nxt   = 1'b1;
          w_fb_addr_nxt = w_gnt_addr;
          w_fb_data_nxt = w_gnt_data;
        end else begin
          w_fb_we_nxt   = 1'b0;
        end
      end
      default: begin
        w_fb_we_nxt = 1'b0;
      end
    endcase
  end

  // Output, round-robin pointer and drop counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fb_we    <= 1'b0;
      r_fb_addr  <= '0;
      r_fb_data  <= 1'b0;
      r_busy     <= 1'b0;
      r_last     <= SRC_T;
      r_drop_cnt <= 16'd0;
    end else begin
      r_fb_we   <= w_fb_we_nxt;
      r_fb_addr <= w_fb_addr_nxt;
      r_fb_data <= w_fb_data_nxt;
      r_busy    <= w_busy_nxt;
      if (w_grant) begin
        r_last <= w_grant_t ? SRC_T : SRC_M;
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign bus.m_ack      = w_grant_m;
  assign bus.t_ack      = w_grant_t;
  assign bus.fb_we      = r_fb_we;
  assign bus.fb_addr    = r_fb_addr;
  assign bus.fb_data    = r_fb_data;
  assign bus.clear_busy = r_busy;
  assign bus.drop_cnt   = r_drop_cnt;

endmodule
